elastic_buffer: RTL and testbench

//  Registered, backpressure-aware counterpart of the combinational buffer: moves

---
 rtl/buffer_pkg.sv | 25 ++
 rtl/buffer_mem.sv | 28 ++
 rtl/elastic_buffer.sv | 115 +++++++++++
 tb/tb_elastic_buffer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared constants and elaboration-time helpers for the elastic buffer family.
package buffer_pkg;

    localparam int unsigned DEF_WIDTH     = 32'd8;
    localparam int unsigned DEF_DEPTH     = 32'd4;
    localparam int unsigned DEF_AFULL_LVL = 32'd3;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 32'd0;
        if (value > 32'd1) begin
            v = value - 32'd1;
            while (v > 32'd0) begin
                result = result + 32'd1;
                v      = v >> 1;
            end
        end else begin
            result = 32'd0;
        end
        return result;
    endfunction

endpackage

// File: rtl/buffer_mem.sv
// DEPTH x WIDTH register array with one write port and an asynchronous read
// port. Contents are deliberately not reset; validity is tracked by the
// controller's occupancy count.
module buffer_mem #(
    parameter int unsigned WIDTH = 32'd8,
    parameter int unsigned DEPTH = 32'd4,
    parameter int unsigned PTR_W = 32'd2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Capture one entry per accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/elastic_buffer.sv
// Registered ready/valid elastic buffer. Handshake flags are derived from the
// next occupancy and registered, so in_ready/out_valid never depend
// combinationally on in_valid or out_ready.
module elastic_buffer
    import buffer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AFULL_LVL = DEF_AFULL_LVL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic [clog2(DEPTH):0] count,
    output logic                  almost_full
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 32'd1;

    localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL  = CNT_W'(AFULL_LVL);

    // Parameter sanity: pointers must wrap naturally, threshold must be reachable.
    if ((DEPTH < 32'd2) || ((DEPTH & (DEPTH - 32'd1)) != 32'd0)) begin : g_bad_depth
        $error("elastic_buffer: DEPTH must be a power of 2 and >= 2");
    end
    if ((AFULL_LVL < 32'd1) || (AFULL_LVL > DEPTH)) begin : g_bad_afull
        $error("elastic_buffer: AFULL_LVL must be within 1..DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             almost_full_r;
    logic             push_s;
    logic             pop_s;
    logic             wr_en_s;
    logic [WIDTH-1:0] rd_data_s;

    assign push_s  = in_valid & in_ready_r;
    assign pop_s   = out_valid_r & out_ready;
    // A flushed or reset cycle drops its incoming word entirely.
    assign wr_en_s = push_s & ~flush & ~rst;

    // Next occupancy from the push/pop pair of this cycle.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointer, occupancy and handshake-flag registers; reset and flush both
    // return to the empty state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            count_r       <= CNT_ZERO;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            almost_full_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r       <= count_nxt_s;
            in_ready_r    <= (count_nxt_s != CNT_FULL);
            out_valid_r   <= (count_nxt_s != CNT_ZERO);
            almost_full_r <= (count_nxt_s >= CNT_AFULL);
        end
    end

    buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (in_data),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    // Head entry is presented only while valid so stale storage never leaks.
    assign out_data    = out_valid_r ? rd_data_s : {WIDTH{1'b0}};
    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign count       = count_r;
    assign almost_full = almost_full_r;

endmodule

// File: tb/tb_elastic_buffer.sv
// Self-checking bench for elastic_buffer: directed vector table, a streaming
// wrap sequence, and a randomized run against a queue-based reference model.
module tb_elastic_buffer;

    localparam int DEPTH = 4;
    localparam int AFULL = 3;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       flush;
    logic [2:0] count;
    logic       almost_full;

    int total;
    int bad;

    elastic_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .flush       (flush),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       flush;
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_cnt;
        logic       e_af;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic iv, input logic [7:0] id,
                       input logic ordy, input logic ir, input logic ov, input logic [7:0] od,
                       input logic [2:0] cnt, input logic af);
        vec_t v;
        v.rst = r; v.flush = f; v.in_valid = iv; v.in_data = id; v.out_ready = ordy;
        v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.e_cnt = cnt; v.e_af = af;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] got[$];
        logic [7:0] mq[$];
        logic       iv, ordy, fl, push, pop;
        logic [7:0] d;

        total = 0;
        bad   = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        //   rst  flush iv   data   ordy | ir   ov   od     cnt   af
        // reset held two cycles
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
        // fill with downstream stalled; fifth push refused
        add(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3, 1'b1);
        add(1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1);
        add(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1);
        // drain in order
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3'd3, 1'b1);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd2, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 3'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
        // refill, then offer 8'hAA while popping: refused at full, accepted
        // next cycle alongside a pop with count holding
        add(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 3'd1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 3'd2, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 3'd3, 1'b1);
        add(1'b0, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4, 1'b1);
        add(1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 8'h02, 3'd3, 1'b1);
        add(1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 8'h03, 3'd3, 1'b1);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hAA, 3'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
        // flush at count 3 with a push offered: the flushed word is dropped
        add(1'b0, 1'b0, 1'b1, 8'h51, 1'b0, 1'b1, 1'b1, 8'h51, 3'd1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'h52, 1'b0, 1'b1, 1'b1, 8'h51, 3'd2, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'h53, 1'b0, 1'b1, 1'b1, 8'h51, 3'd3, 1'b1);
        add(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'h61, 1'b0, 1'b1, 1'b1, 8'h61, 3'd1, 1'b0);
        // reset with flush mid-transfer
        add(1'b0, 1'b0, 1'b1, 8'h62, 1'b0, 1'b1, 1'b1, 8'h61, 3'd2, 1'b0);
        add(1'b1, 1'b1, 1'b1, 8'h63, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            flush     = vecs[i].flush;
            in_valid  = vecs[i].in_valid;
            in_data   = vecs[i].in_data;
            out_ready = vecs[i].out_ready;
            @(posedge clk);
            #1;
            check($sformatf("v%0d.in_ready", i),    32'(in_ready),    32'(vecs[i].e_ir));
            check($sformatf("v%0d.out_valid", i),   32'(out_valid),   32'(vecs[i].e_ov));
            check($sformatf("v%0d.out_data", i),    32'(out_data),    32'(vecs[i].e_od));
            check($sformatf("v%0d.count", i),       32'(count),       32'(vecs[i].e_cnt));
            check($sformatf("v%0d.almost_full", i), 32'(almost_full), 32'(vecs[i].e_af));
        end
        rst = 1'b0; flush = 1'b0;

        // stream 10 words with both sides open; pointers wrap repeatedly
        for (int k = 0; k < 14; k++) begin
            in_valid  = (k < 10);
            in_data   = 8'(8'h20 + k);
            out_ready = 1'b1;
            if (out_valid) got.push_back(out_data);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("stream.len", 32'(got.size()), 32'd10);
        for (int k = 0; k < got.size() && k < 10; k++) begin
            check($sformatf("stream.w%0d", k), 32'(got[k]), 32'(8'h20 + k));
        end
        check("stream.count_end", 32'(count), 32'd0);

        // randomized traffic against a queue reference
        mq.delete();
        for (int c = 0; c < 1000; c++) begin
            check($sformatf("r%0d.count", c),     32'(count),     32'(mq.size()));
            check($sformatf("r%0d.out_valid", c), 32'(out_valid), 32'(mq.size() != 0));
            check($sformatf("r%0d.in_ready", c),  32'(in_ready),  32'(mq.size() != DEPTH));
            check($sformatf("r%0d.afull", c),     32'(almost_full), 32'(mq.size() >= AFULL));
            if (mq.size() != 0) begin
                check($sformatf("r%0d.out_data", c), 32'(out_data), 32'(mq[0]));
            end
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 1) != 0);
            fl   = ($urandom_range(0, 63) == 0);
            d    = 8'($urandom_range(0, 255));
            in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
            push = iv && (mq.size() < DEPTH);
            pop  = ordy && (mq.size() > 0);
            @(posedge clk);
            if (fl) begin
                mq.delete();
            end else begin
                if (pop)  void'(mq.pop_front());
                if (push) mq.push_back(d);
            end
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
